// File: rtl/sram_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between the instruction and data
// SRAM-like read ports; one outstanding read per port, responses steered back by RID.
module sram_axi_rd_arbiter #(
  parameter logic [3:0] INST_ID         = 4'd0,
  parameter logic [3:0] DATA_ID         = 4'd1,
  parameter bit         RESET_PRIO_DATA = 1'b1
) (
  input  logic        aclk,
  input  logic        areset,
  // Instruction read port
  input  logic        inst_rd_req,
  input  logic [1:0]  inst_rd_size,
  input  logic [31:0] inst_rd_addr,
  output logic        inst_rd_addr_ok,
  output logic        inst_rd_data_ok,
  output logic [31:0] inst_rd_rdata,
  // Data read port
  input  logic        data_rd_req,
  input  logic [1:0]  data_rd_size,
  input  logic [31:0] data_rd_addr,
  output logic        data_rd_addr_ok,
  output logic        data_rd_data_ok,
  output logic [31:0] data_rd_rdata,
  // AXI AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  input  logic        rlast,
  output logic        rready,
  output logic        unexp_rid
);

  logic        r_arvalid;
  logic [3:0]  r_arid;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic        r_busy_inst;
  logic        r_busy_data;
  logic        r_rr_data;
  logic        r_rready;

  logic w_inst_elig;
  logic w_data_elig;
  logic w_inst_grant;
  logic w_data_grant;
  logic w_r_hs;
  logic w_inst_resp;
  logic w_data_resp;
  logic w_rlast_unused;

  assign w_rlast_unused = rlast;

  // The AR slot is free only while arvalid is low, so no accept can share the handshake cycle.
  assign w_inst_elig  = inst_rd_req & ~r_busy_inst & ~r_arvalid;
  assign w_data_elig  = data_rd_req & ~r_busy_data & ~r_arvalid;
  assign w_data_grant = w_data_elig & (~w_inst_elig | r_rr_data);
  assign w_inst_grant = w_inst_elig & (~w_data_elig | ~r_rr_data);

  assign w_r_hs      = rvalid & r_rready;
  assign w_inst_resp = w_r_hs & (rid == INST_ID) & r_busy_inst;
  assign w_data_resp = w_r_hs & (rid == DATA_ID) & r_busy_data;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_arvalid   <= 1'b0;
      r_arid      <= 4'd0;
      r_araddr    <= 32'd0;
      r_arsize    <= 3'd0;
      r_busy_inst <= 1'b0;
      r_busy_data <= 1'b0;
      r_rr_data   <= RESET_PRIO_DATA;
      r_rready    <= 1'b0;
    end else begin
      r_rready <= 1'b1;
      if (w_data_grant) begin
        r_arvalid   <= 1'b1;
        r_arid      <= DATA_ID;
        r_araddr    <= data_rd_addr;
        r_arsize    <= {1'b0, data_rd_size};
        r_busy_data <= 1'b1;
        r_rr_data   <= 1'b0;
      end else if (w_inst_grant) begin
        r_arvalid   <= 1'b1;
        r_arid      <= INST_ID;
        r_araddr    <= inst_rd_addr;
        r_arsize    <= {1'b0, inst_rd_size};
        r_busy_inst <= 1'b1;
        r_rr_data   <= 1'b1;
      end else if (r_arvalid && arready) begin
        r_arvalid <= 1'b0;
      end
      // A port cannot be granted while busy, so these never collide with the sets above.
      if (w_inst_resp) r_busy_inst <= 1'b0;
      if (w_data_resp) r_busy_data <= 1'b0;
    end
  end

  assign inst_rd_addr_ok = w_inst_grant;
  assign data_rd_addr_ok = w_data_grant;
  assign inst_rd_data_ok = w_inst_resp;
  assign data_rd_data_ok = w_data_resp;
  assign inst_rd_rdata   = w_inst_resp ? rdata : 32'd0;
  assign data_rd_rdata   = w_data_resp ? rdata : 32'd0;
  assign unexp_rid       = w_r_hs & ~w_inst_resp & ~w_data_resp;

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arsize  = r_arsize;
  assign arvalid = r_arvalid;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = r_rready;

endmodule

// File: tb/tb_sram_axi_rd_arbiter.sv
// Directed bench for sram_axi_rd_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, state updates on the rising edge.
module tb_sram_axi_rd_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic        inst_rd_req, data_rd_req;
  logic [1:0]  inst_rd_size, data_rd_size;
  logic [31:0] inst_rd_addr, data_rd_addr;
  logic        inst_rd_addr_ok, inst_rd_data_ok, data_rd_addr_ok, data_rd_data_ok;
  logic [31:0] inst_rd_rdata, data_rd_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rlast, rready, unexp_rid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  sram_axi_rd_arbiter dut (
    .aclk(aclk), .areset(areset),
    .inst_rd_req(inst_rd_req), .inst_rd_size(inst_rd_size), .inst_rd_addr(inst_rd_addr),
    .inst_rd_addr_ok(inst_rd_addr_ok), .inst_rd_data_ok(inst_rd_data_ok),
    .inst_rd_rdata(inst_rd_rdata),
    .data_rd_req(data_rd_req), .data_rd_size(data_rd_size), .data_rd_addr(data_rd_addr),
    .data_rd_addr_ok(data_rd_addr_ok), .data_rd_data_ok(data_rd_data_ok),
    .data_rd_rdata(data_rd_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
    .rready(rready), .unexp_rid(unexp_rid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_rid;
  logic [31:0] exp_rdata;
  logic exp_data_grant;
  int g;

  initial begin
    areset = 1'b1;
    inst_rd_req = 0; data_rd_req = 0;
    inst_rd_size = 0; data_rd_size = 0;
    inst_rd_addr = 0; data_rd_addr = 0;
    arready = 0; rid = 0; rdata = 0; rvalid = 0; rlast = 1;

    // Reset state
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_rready", rready, 0);
    chk("rst_unexp", unexp_rid, 0);
    @(negedge aclk);
    areset = 1'b0;
    #1 chk("rready_0_before_edge", rready, 0);
    @(negedge aclk);
    #1 chk("rready_after_release", rready, 1);

    // Single instruction read
    inst_rd_req = 1; inst_rd_addr = 32'h1C00_0000; inst_rd_size = 2;
    #1;
    chk("t1_inst_addr_ok", inst_rd_addr_ok, 1);
    chk("t1_data_addr_ok", data_rd_addr_ok, 0);
    @(negedge aclk);
    inst_rd_req = 0; arready = 1;
    #1;
    chk("t1_arvalid", arvalid, 1);
    chk("t1_arid", arid, 0);
    chk("t1_araddr", araddr, 32'h1C00_0000);
    chk("t1_arsize", arsize, 3'b010);
    chk("t1_arlen", arlen, 0);
    chk("t1_arburst", arburst, 2'b01);
    @(negedge aclk);
    arready = 0;
    #1 chk("t1_arvalid_drop", arvalid, 0);
    @(negedge aclk);
    rvalid = 1; rid = 0; rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_inst_data_ok", inst_rd_data_ok, 1);
    chk("t1_inst_rdata", inst_rd_rdata, 32'hDEAD_BEEF);
    chk("t1_data_data_ok", data_rd_data_ok, 0);
    chk("t1_unexp", unexp_rid, 0);
    @(negedge aclk);
    rvalid = 0; inst_rd_req = 1;
    #1 chk("t1_busy_cleared", inst_rd_addr_ok, 1);
    inst_rd_req = 0;

    // Both ports requesting: grants alternate data, inst, data, inst
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      inst_rd_req = 1; data_rd_req = 1; arready = 1;
      inst_rd_addr = 32'h0000_1000; data_rd_addr = 32'h0000_2000;
      g = c / 2;
      if (c % 2 == 0 && g > 0) begin
        rvalid = 1;
        exp_rid = ((g - 1) % 2 == 0) ? 4'd1 : 4'd0;
        rid = exp_rid;
        exp_rdata = 32'h0000_1000 + 32'(g - 1);
        rdata = exp_rdata;
      end else begin
        rvalid = 0;
      end
      exp_data_grant = (g % 2 == 0);
      #1;
      if (c % 2 == 0) begin
        chk("t2_data_addr_ok", data_rd_addr_ok, exp_data_grant);
        chk("t2_inst_addr_ok", inst_rd_addr_ok, !exp_data_grant);
        if (g > 0) begin
          chk("t2_data_ok_d", data_rd_data_ok, exp_rid == 4'd1);
          chk("t2_data_ok_i", inst_rd_data_ok, exp_rid == 4'd0);
          chk("t2_rdata", (exp_rid == 4'd1) ? data_rd_rdata : inst_rd_rdata, exp_rdata);
        end
      end else begin
        chk("t2_arvalid", arvalid, 1);
        chk("t2_arid", arid, exp_data_grant ? 4'd1 : 4'd0);
        chk("t2_no_addr_ok", {inst_rd_addr_ok, data_rd_addr_ok}, 0);
      end
    end
    @(negedge aclk);
    inst_rd_req = 0; data_rd_req = 0; arready = 0;
    rvalid = 1; rid = 0; rdata = 32'h0000_1003;
    #1;
    chk("t2_last_inst_ok", inst_rd_data_ok, 1);
    chk("t2_last_rdata", inst_rd_rdata, 32'h0000_1003);

    // AR stall for 5 cycles, then inst issued while data read outstanding
    @(negedge aclk);
    rvalid = 0;
    data_rd_req = 1; data_rd_addr = 32'h8000_0010; data_rd_size = 1;
    #1 chk("t3_data_addr_ok", data_rd_addr_ok, 1);
    @(negedge aclk);
    inst_rd_req = 1; inst_rd_addr = 32'h1C00_0040; inst_rd_size = 2;
    data_rd_addr = 32'h0BAD_0BAD;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_hold_arvalid", arvalid, 1);
      chk("t3_hold_arid", arid, 1);
      chk("t3_hold_araddr", araddr, 32'h8000_0010);
      chk("t3_hold_arsize", arsize, 3'b001);
      chk("t3_hold_no_addr_ok", {inst_rd_addr_ok, data_rd_addr_ok}, 0);
      @(negedge aclk);
    end
    arready = 1;
    #1 chk("t3_hs_no_addr_ok", {inst_rd_addr_ok, data_rd_addr_ok}, 0);
    @(negedge aclk);
    arready = 0;
    #1;
    chk("t3_inst_addr_ok", inst_rd_addr_ok, 1);
    chk("t4_data_blocked", data_rd_addr_ok, 0);
    @(negedge aclk);
    inst_rd_req = 0; arready = 1;
    #1;
    chk("t4_arid_inst", arid, 0);
    chk("t4_araddr_inst", araddr, 32'h1C00_0040);
    @(negedge aclk);
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h1111_1111;
    #1;
    chk("t4_inst_ok_first", inst_rd_data_ok, 1);
    chk("t4_inst_rdata", inst_rd_rdata, 32'h1111_1111);
    chk("t4_data_not_ok", data_rd_data_ok, 0);
    chk("t4_data_still_blocked", data_rd_addr_ok, 0);
    @(negedge aclk);
    rid = 1; rdata = 32'h2222_2222;
    #1;
    chk("t4_data_ok", data_rd_data_ok, 1);
    chk("t4_data_rdata", data_rd_rdata, 32'h2222_2222);
    chk("t4_inst_not_ok", inst_rd_data_ok, 0);
    chk("t4_same_cycle_no_accept", data_rd_addr_ok, 0);
    @(negedge aclk);
    rvalid = 0;
    #1 chk("t4_next_cycle_accept", data_rd_addr_ok, 1);
    data_rd_req = 0;

    // Unexpected RID
    @(negedge aclk);
    rvalid = 1; rid = 1; rdata = 32'h3333_3333;
    #1;
    chk("t5_unexp", unexp_rid, 1);
    chk("t5_no_data_ok", {inst_rd_data_ok, data_rd_data_ok}, 0);
    chk("t5_data_rdata_zero", data_rd_rdata, 0);
    @(negedge aclk);
    rvalid = 0; data_rd_req = 1;
    #1;
    chk("t5_unexp_pulse", unexp_rid, 0);
    chk("t5_arvalid", arvalid, 0);
    chk("t5_state_kept", data_rd_addr_ok, 1);
    data_rd_req = 0;

    // Reset mid-transaction
    @(negedge aclk);
    inst_rd_req = 1; inst_rd_addr = 32'h1C00_0080;
    @(negedge aclk);
    inst_rd_req = 0;
    #1 chk("t6_arvalid_pre", arvalid, 1);
    #1 areset = 1'b1;
    #1;
    chk("t6_async_arvalid", arvalid, 0);
    chk("t6_async_rready", rready, 0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    rvalid = 1; rid = 0; rdata = 32'h4444_4444;
    #1;
    chk("t6_unexp", unexp_rid, 1);
    chk("t6_no_inst_ok", inst_rd_data_ok, 0);
    @(negedge aclk);
    rvalid = 0; inst_rd_req = 1; data_rd_req = 1;
    #1;
    chk("t6_prio_data", data_rd_addr_ok, 1);
    chk("t6_prio_inst", inst_rd_addr_ok, 0);
    inst_rd_req = 0; data_rd_req = 0;

    @(negedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_axi_rd_arbiter.md
Name: sram_axi_rd_arbiter

Overview:
Shares the single AXI read channel (AR/R) between the instruction and data SRAM-like read ports of the CPU core. Each requester is granted round-robin and tagged with a fixed ARID. At most one read is in flight per requester, and responses are steered back by RID. The block sits between the core's SRAM-like read requests and the AXI read master side of the SRAM-to-AXI bridge.

Parameters:
INST_ID, 4'd0, ARID/RID value used for instruction reads
DATA_ID, 4'd1, ARID/RID value used for data reads (must differ from INST_ID)
RESET_PRIO_DATA, 1, round-robin pointer after reset (1 = data port wins first tie)

Ports:
aclk  in  1  clock
areset  in  1  reset, asynchronous, active-high
inst_rd_req  in  1  instruction read request
inst_rd_size  in  2  log2 bytes (0=1B, 1=2B, 2=4B)
inst_rd_addr  in  32  instruction read address
inst_rd_addr_ok  out  1  request accepted this cycle
inst_rd_data_ok  out  1  read data valid this cycle
inst_rd_rdata  out  32  read data
data_rd_req / data_rd_size / data_rd_addr / data_rd_addr_ok / data_rd_data_ok / data_rd_rdata  same widths and meaning, data port
arid  out  4  read ID
araddr  out  32  read address
arlen  out  8  constant 0
arsize  out  3  {1'b0, size}
arburst  out  2  constant 2'b01
arlock  out  2  constant 0
arcache  out  4  constant 0
arprot  out  3  constant 0
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  response ID
rdata  in  32  response data
rvalid  in  1  response valid
rlast  in  1  last beat (always 1 for arlen=0; not checked)
rready  out  1  response ready
unexp_rid  out  1  one-cycle pulse: response with no matching outstanding read

Behaviour:
- Reset (areset=1, async): arvalid=0, arid/araddr/arsize=0, busy_inst=busy_data=0, rr pointer=RESET_PRIO_DATA, rready=0, all *_addr_ok=0, *_data_ok=0, unexp_rid=0, *_rdata=0.
- rready=1 in every cycle after reset deasserts (registered, 1 cycle after release).
- AR slot is a single register. It is "free" when arvalid=0.
- Eligibility: port X is eligible when X_rd_req=1, busy_X=0 and the AR slot is free.
- Grant (combinational):
  - Exactly one port eligible: that port wins.
  - Both eligible: the port selected by the rr pointer wins.
  - X_rd_addr_ok=1 only for the winner in that cycle, so at most one addr_ok per cycle.
- On accept (req & addr_ok, rising edge):
  - arvalid<=1; araddr<=addr; arsize<={1'b0,size}; arid<=X_ID; busy_X<=1.
  - rr pointer flips to the other port.
- AR hold: arvalid, arid, araddr and arsize stay stable until arvalid&arready. arvalid<=0 that cycle. No new accept is possible in the same cycle as the handshake; the slot is free the following cycle.
- Response (rvalid&rready):
  - rid==X_ID and busy_X=1: X_rd_data_ok=1 and X_rd_rdata=rdata, combinational same cycle; busy_X<=0.
  - Otherwise: no data_ok; unexp_rid=1 for that cycle.
  - X_rd_rdata is don't-care when data_ok=0; drive 0.
- A response clearing busy_X and a new X request in the same cycle: the request is not eligible that cycle and is accepted next cycle at the earliest.
- Responses may return in either order; there is no ordering between ports.
- Latency: req to AR presented = 1 cycle; best-case req to data_ok = 3 cycles (accept, arready, rvalid).
- size=3 is illegal. arsize is still driven as {1'b0,size}; no check is performed.
- Reset mid-transaction clears all state. Responses to pre-reset reads then arrive as unexpected: they are consumed and flagged on unexp_rid, with no data_ok.

Test Plan:
- Single inst read, addr 0x1C000000, size 2; arready on first arvalid cycle, rvalid 2 cycles later with rid=0, rdata=0xDEADBEEF -> inst_rd_addr_ok pulse cycle 0; arvalid cycle 1 with arid=0, arsize=3'b010, arlen=0, arburst=01; inst_rd_data_ok=1 with rdata 0xDEADBEEF; busy cleared.
- Both ports request continuously from reset, arready=1, rvalid immediate -> grants alternate data, inst, data, inst (arid 1,0,1,0); never two addr_ok in one cycle.
- arready held 0 for 5 cycles -> arvalid/araddr/arid stable for all 5 cycles; no addr_ok to either port until 1 cycle after the handshake.
- Data read outstanding (rid=1 not yet returned), data_rd_req stays high -> data_rd_addr_ok stays 0; inst read issued meanwhile; return rid=0 before rid=1 -> each data_ok goes to the correct port with the correct rdata.
- rvalid with rid=1 while busy_data=0 -> unexp_rid=1 for one cycle; no data_ok; state unchanged.
- areset pulsed while arvalid=1 and busy_inst=1 -> arvalid=0 immediately (asynchronously); later rvalid with rid=0 -> unexp_rid=1 and no inst_rd_data_ok.
